// File: rtl/uart_tx_fsm.sv
// UART transmit framer: start bit, LSB-first data, optional parity, one stop bit.
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
`timescale 1ns/1ps

module uart_tx_fsm #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      clk,
    input  logic                      syn_reset,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      data_valid,
    input  logic                      parity_enable,
    input  logic                      parity_type,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    output logic                      TX_OUT,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY
`endif
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_d;
    logic [PRESCALE_WIDTH-1:0] last_edge;
    logic [BIT_CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]     shreg_q, shreg_d;
    logic                      tx_d, busy_d, done_d;
    logic                      bit_end;

`ifdef UART_TX_PARITY_EN
    logic par_en_q, par_en_d;
    logic par_bit_q, par_bit_d;
`else
    logic unused_parity_cfg;
    assign unused_parity_cfg = parity_enable ^ parity_type;
`endif

    // prescale of 0 wraps to all-ones here, which yields 2^PRESCALE_WIDTH cycles per bit.
    assign last_edge = prescale_q - PRESCALE_WIDTH'(1);
    assign bit_end   = (edge_cnt_q == last_edge);

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        prescale_d = prescale_q;
        done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
`endif

        if (state_q != S_IDLE) begin
            edge_cnt_d = bit_end ? '0 : edge_cnt_q + PRESCALE_WIDTH'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (data_valid && !busy) begin
                    state_d    = S_START;
                    edge_cnt_d = '0;
                    shreg_d    = P_DATA;
                    prescale_d = prescale;
`ifdef UART_TX_PARITY_EN
                    par_en_d   = parity_enable;
                    par_bit_d  = (^P_DATA) ^ parity_type;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = par_en_q ? S_PARITY : S_STOP;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are derived from the next state so the flops present them with no extra lag.
        busy_d = (state_d != S_IDLE);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shreg_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_bit_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_reset) begin
            state_q    <= S_IDLE;
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shreg_q    <= '0;
            prescale_q <= '0;
            TX_OUT     <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q    <= state_d;
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shreg_q    <= shreg_d;
            prescale_q <= prescale_d;
            TX_OUT     <= tx_d;
            busy       <= busy_d;
            frame_done <= done_d;
`ifdef UART_TX_PARITY_EN
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Scoreboard bench for uart_tx_fsm: a frame-level model queues expected frames,
// a monitor checks the serial line cycle by cycle. Honours UART_TX_PARITY_EN.
`timescale 1ns/1ps

module tb_uart_tx_fsm;

`ifdef UART_TX_PARITY_EN
    localparam bit PARITY_BUILD = 1'b1;
`else
    localparam bit PARITY_BUILD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       syn_reset;
    logic [7:0] P_DATA;
    logic       data_valid;
    logic       parity_enable;
    logic       parity_type;
    logic [5:0] prescale;
    logic       TX_OUT;
    logic       busy;
    logic       frame_done;

    uart_tx_fsm dut (
        .clk          (clk),
        .syn_reset    (syn_reset),
        .P_DATA       (P_DATA),
        .data_valid   (data_valid),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .prescale     (prescale),
        .TX_OUT       (TX_OUT),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] bits;   // line value per bit slot, slot 0 = start bit
        int          nbits;
        int          p;
    } frame_t;

    frame_t exp_q[$];
    frame_t new_frame;
    frame_t cur;
    int     n_cmp = 0;
    int     n_fail = 0;
    int     model_rem = 0;
    bit     abort_flag = 1'b0;
    bit     mon_active = 1'b0;
    int     mon_cycle = 0;
    int     frames_seen = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s frame=%0d cycle=%0d: got %0h, expected %0h at %0t",
                     name, frames_seen, mon_cycle, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic frame_t make_frame(input logic [7:0] d, input logic pe,
                                          input logic pt, input logic [5:0] ps);
        frame_t f;
        int     n;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1 + i] = d[i];
        n = 9;
        if (pe && PARITY_BUILD) begin
            f.bits[n] = ($countones(d) % 2 == 1) ^ pt;
            n++;
        end
        f.bits[n] = 1'b1;
        f.nbits = n + 1;
        f.p = (ps == 6'd0) ? 64 : int'(ps);
        return f;
    endfunction

    // Reference model: decides acceptance from its own notion of frame length.
    always @(posedge clk) begin
        if (syn_reset) begin
            model_rem = 0;
            exp_q.delete();
            abort_flag = 1'b1;
        end else if (model_rem == 0) begin
            if (data_valid) begin
                new_frame = make_frame(P_DATA, parity_enable, parity_type, prescale);
                exp_q.push_back(new_frame);
                model_rem = new_frame.nbits * new_frame.p;
            end
        end else begin
            model_rem--;
        end
    end

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (abort_flag) begin
            check("reset_tx", TX_OUT, 1);
            check("reset_busy", busy, 0);
            check("reset_done", frame_done, 0);
            mon_active = 1'b0;
            abort_flag = 1'b0;
        end else if (!mon_active && TX_OUT !== 1'b0) begin
            check("idle_tx", TX_OUT, 1);
            check("idle_busy", busy, 0);
            check("idle_done", frame_done, 0);
        end else begin
            if (!mon_active) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_start_bit");
                end else begin
                    cur = exp_q.pop_front();
                    mon_active = 1'b1;
                    mon_cycle = 0;
                end
            end
            if (mon_active) begin
                if (mon_cycle < cur.nbits * cur.p) begin
                    check("line_bit", TX_OUT, cur.bits[mon_cycle / cur.p]);
                    check("frame_busy", busy, 1);
                    check("frame_done_early", frame_done, 0);
                end else begin
                    check("done_pulse", frame_done, 1);
                    check("done_busy", busy, 0);
                    check("done_tx", TX_OUT, 1);
                    mon_active = 1'b0;
                    frames_seen++;
                end
                mon_cycle++;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        P_DATA = d;
        parity_enable = pe;
        parity_type = pt;
        prescale = ps;
        data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while ((model_rem != 0 || exp_q.size() != 0 || mon_active) && k < 5000) begin
            tick(1);
            k++;
        end
        if (k >= 5000) fail_now({"timeout_", name});
        tick(2);
    endtask

    initial begin
        syn_reset = 1'b1;
        P_DATA = '0;
        data_valid = 1'b0;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        prescale = 6'd8;

        // Reset for 3 cycles, then idle for 20.
        tick(3);
        syn_reset = 1'b0;
        tick(20);

        // Even-parity frame, 0xA5 at 8 cycles per bit.
        send(8'hA5, 1'b1, 1'b0, 6'd8);
        wait_idle("parity_frame");

        // Odd parity on an all-zero byte at 16 cycles per bit.
        send(8'h00, 1'b1, 1'b1, 6'd16);
        wait_idle("odd_parity");

        // Second request and config change while busy must be ignored.
        P_DATA = 8'h3C; parity_enable = 1'b0; prescale = 6'd4; data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        tick(8);
        P_DATA = 8'hFF; prescale = 6'd8; data_valid = 1'b1;
        tick(1);
        data_valid = 1'b0;
        wait_idle("busy_latching");

        // Back-to-back frames with prescale wrap (64 cycles per bit).
        parity_enable = 1'b0;
        prescale = 6'd0;
        data_valid = 1'b1;
        for (int i = 0; i < 1925; i++) begin
            P_DATA = 8'($urandom);
            tick(1);
        end
        data_valid = 1'b0;
        wait_idle("back_to_back");

        // Reset during data bit 3, then a fresh frame.
        send(8'h96, 1'b1, 1'b1, 6'd5);
        tick(20);
        syn_reset = 1'b1;
        tick(1);
        syn_reset = 1'b0;
        tick(3);
        send(8'h5A, 1'b1, 1'b0, 6'd5);
        wait_idle("after_reset");

        // Randomised traffic, including requests that land while busy.
        for (int i = 0; i < 3000; i++) begin
            data_valid = ($urandom_range(0, 3) == 0);
            P_DATA = 8'($urandom);
            parity_enable = 1'($urandom);
            parity_type = 1'($urandom);
            prescale = ($urandom_range(0, 7) == 0) ? 6'd1 : 6'($urandom_range(2, 9));
            tick(1);
        end
        data_valid = 1'b0;
        wait_idle("random");

        check("queue_drained", exp_q.size(), 0);
        check("monitor_idle", mon_active, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
